// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM state codes.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Which requester owns the in-flight memory access.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    // Bit positions inside the one-hot grant vector.
    localparam int PICK_IF = 0;
    localparam int PICK_D  = 1;

    // Saturating increment of the 4-bit starvation counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic [3:0] lim);
        logic [3:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests.
// Data wins by default; fetch wins when the starvation limit has been hit.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       starve_hit,
    output logic [1:0] gnt_oh
);

    // One-hot grant: bit PICK_IF for fetch, bit PICK_D for data.
    always_comb begin
        gnt_oh = 2'b00;
        if (d_req && !(if_req && starve_hit)) begin
            gnt_oh[PICK_D] = 1'b1;
        end else if (if_req) begin
            gnt_oh[PICK_IF] = 1'b1;
        end else begin
            gnt_oh = 2'b00;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port.
// One transaction at a time: grant in IDLE, wait MEM_LAT cycles, return rvalid.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT_INIT     = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM   = 4'(STARVE_MAX);
    localparam logic       SINGLE_CYCLE = (MEM_LAT == 32'sd1) ? 1'b1 : 1'b0;

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic        op_wr_q, op_wr_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic        idle_s;
    logic        starve_hit_s;
    logic [1:0]  pick_s;

    logic              if_gnt_s, if_rvalid_s, d_gnt_s, d_rvalid_s;
    logic [DATA_W-1:0] if_rdata_s, d_rdata_s, mem_wdata_s;
    logic              mem_en_s, mem_wr_s;
    logic [ADDR_W-1:0] mem_addr_s;

    assign idle_s       = (state_q == ARB_IDLE);
    assign starve_hit_s = (starve_cnt_q == STARVE_LIM);

    // Requests only compete while the port is idle.
    mem_arb_pick u_pick (
        .if_req     (if_req & idle_s),
        .d_req      (d_req & idle_s),
        .starve_hit (starve_hit_s),
        .gnt_oh     (pick_s)
    );

    // State, ownership, latency and starvation registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            op_wr_q      <= 1'b0;
            lat_cnt_q    <= 3'd0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_wr_q      <= op_wr_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state logic plus grant, memory command and response muxing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_wr_d      = op_wr_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_gnt_s     = 1'b0;
        d_gnt_s      = 1'b0;
        if_rvalid_s  = 1'b0;
        d_rvalid_s   = 1'b0;
        if_rdata_s   = '0;
        d_rdata_s    = '0;
        mem_en_s     = 1'b0;
        mem_wr_s     = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_s[PICK_D]) begin
                    d_gnt_s     = 1'b1;
                    mem_en_s    = 1'b1;
                    mem_wr_s    = d_wr;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    owner_d     = OWN_D;
                    op_wr_d     = d_wr;
                    // Only a data grant that overtakes a waiting fetch counts.
                    if (if_req) begin
                        starve_cnt_d = sat_inc4(starve_cnt_q, STARVE_LIM);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else if (pick_s[PICK_IF]) begin
                    if_gnt_s     = 1'b1;
                    mem_en_s     = 1'b1;
                    mem_addr_s   = if_addr;
                    owner_d      = OWN_IF;
                    op_wr_d      = 1'b0;
                    starve_cnt_d = 4'd0;
                end else begin
                    owner_d = owner_q;
                end
                if (pick_s != 2'b00) begin
                    if (SINGLE_CYCLE) begin
                        state_d = ARB_RESP;
                    end else begin
                        state_d   = ARB_WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q <= 3'd1) begin
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_RESP: begin
                if (owner_q == OWN_D) begin
                    d_rvalid_s = 1'b1;
                    d_rdata_s  = op_wr_q ? '0 : mem_rdata;
                end else begin
                    if_rvalid_s = 1'b1;
                    if_rdata_s  = mem_rdata;
                end
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs are held quiet while reset is asserted, whatever the requests do.
    always_comb begin
        if (rst) begin
            if_gnt    = if_gnt_s;
            if_rvalid = if_rvalid_s;
            if_rdata  = if_rdata_s;
            d_gnt     = d_gnt_s;
            d_rvalid  = d_rvalid_s;
            d_rdata   = d_rdata_s;
            mem_en    = mem_en_s;
            mem_wr    = mem_wr_s;
            mem_addr  = mem_addr_s;
            mem_wdata = mem_wdata_s;
        end else begin
            if_gnt    = 1'b0;
            if_rvalid = 1'b0;
            if_rdata  = '0;
            d_gnt     = 1'b0;
            d_rvalid  = 1'b0;
            d_rdata   = '0;
            mem_en    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
// A per-instance scoreboard predicts grants and queues expected responses.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_s    [2];
    logic [31:0] if_addr_s   [2];
    logic        d_req_s     [2];
    logic        d_wr_s      [2];
    logic [31:0] d_addr_s    [2];
    logic [31:0] d_wdata_s   [2];
    logic        if_gnt_s    [2];
    logic        if_rvalid_s [2];
    logic [31:0] if_rdata_s  [2];
    logic        d_gnt_s     [2];
    logic        d_rvalid_s  [2];
    logic [31:0] d_rdata_s   [2];
    logic        mem_en_s    [2];
    logic        mem_wr_s    [2];
    logic [31:0] mem_addr_s  [2];
    logic [31:0] mem_wdata_s [2];
    logic [31:0] mem_rdata_s [2];

    int total;
    int bad;

    typedef struct {
        logic        own;
        logic [31:0] data;
        int          due;
    } exp_t;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] rd_addr_r = 32'h0;
        exp_t        sb[$];
        int          cyc = 0;
        int          free_at = 0;
        int          starve = 0;
        logic        exp_if, exp_d;
        exp_t        e;

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req_s[g]), .if_addr(if_addr_s[g]), .if_gnt(if_gnt_s[g]),
            .if_rvalid(if_rvalid_s[g]), .if_rdata(if_rdata_s[g]),
            .d_req(d_req_s[g]), .d_wr(d_wr_s[g]), .d_addr(d_addr_s[g]), .d_wdata(d_wdata_s[g]),
            .d_gnt(d_gnt_s[g]), .d_rvalid(d_rvalid_s[g]), .d_rdata(d_rdata_s[g]),
            .mem_en(mem_en_s[g]), .mem_wr(mem_wr_s[g]), .mem_addr(mem_addr_s[g]),
            .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g])
        );

        // Memory model: capture the command address, read data follows the address.
        always @(posedge clk) begin
            if (mem_en_s[g] === 1'b1) rd_addr_r <= mem_addr_s[g];
        end
        assign mem_rdata_s[g] = data_of(rd_addr_r);

        // Scoreboard monitor.
        initial begin
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst) begin
                    total++;
                    if ({if_gnt_s[g], d_gnt_s[g], if_rvalid_s[g], d_rvalid_s[g], mem_en_s[g], mem_wr_s[g]} !== 6'b0 ||
                        if_rdata_s[g] !== 32'h0 || d_rdata_s[g] !== 32'h0 || mem_addr_s[g] !== 32'h0 || mem_wdata_s[g] !== 32'h0) begin
                        bad++;
                        $display("FAIL reset_quiet[%0d]: cycle %0d outputs not all zero (gnt if/d %b%b mem_en %b), required all 0",
                                 g, cyc, if_gnt_s[g], d_gnt_s[g], mem_en_s[g]);
                    end
                    sb.delete();
                    free_at = 0;
                    starve  = 0;
                end else begin
                    exp_if = (cyc >= free_at) && if_req_s[g] && (!d_req_s[g] || starve == 4);
                    exp_d  = (cyc >= free_at) && d_req_s[g] && !(if_req_s[g] && starve == 4);
                    total++;
                    if ({if_gnt_s[g], d_gnt_s[g]} !== {exp_if, exp_d}) begin
                        bad++;
                        $display("FAIL grant[%0d]: cycle %0d if/d gnt=%b%b, required %b%b", g, cyc,
                                 if_gnt_s[g], d_gnt_s[g], exp_if, exp_d);
                    end
                    total++;
                    if (mem_en_s[g] !== (exp_if | exp_d)) begin
                        bad++;
                        $display("FAIL mem_en[%0d]: cycle %0d got %b, required %b", g, cyc, mem_en_s[g], exp_if | exp_d);
                    end
                    total++;
                    if (exp_d) begin
                        if ({mem_wr_s[g], mem_addr_s[g], mem_wdata_s[g]} !== {d_wr_s[g], d_addr_s[g], d_wdata_s[g]}) begin
                            bad++;
                            $display("FAIL mem_cmd_d[%0d]: cycle %0d wr/addr/wdata=%b/%h/%h, required %b/%h/%h", g, cyc,
                                     mem_wr_s[g], mem_addr_s[g], mem_wdata_s[g], d_wr_s[g], d_addr_s[g], d_wdata_s[g]);
                        end
                        sb.push_back('{own: 1'b1, data: (d_wr_s[g] ? 32'h0 : data_of(d_addr_s[g])), due: cyc + LAT});
                        if (if_req_s[g] && starve < 4) starve++;
                        free_at = cyc + LAT + 1;
                    end else if (exp_if) begin
                        if ({mem_wr_s[g], mem_addr_s[g], mem_wdata_s[g]} !== {1'b0, if_addr_s[g], 32'h0}) begin
                            bad++;
                            $display("FAIL mem_cmd_if[%0d]: cycle %0d wr/addr/wdata=%b/%h/%h, required 0/%h/0", g, cyc,
                                     mem_wr_s[g], mem_addr_s[g], mem_wdata_s[g], if_addr_s[g]);
                        end
                        sb.push_back('{own: 1'b0, data: data_of(if_addr_s[g]), due: cyc + LAT});
                        starve  = 0;
                        free_at = cyc + LAT + 1;
                    end else begin
                        if ({mem_wr_s[g], mem_addr_s[g], mem_wdata_s[g]} !== 65'h0) begin
                            bad++;
                            $display("FAIL mem_idle[%0d]: cycle %0d mem fields not 0 without mem_en", g, cyc);
                        end
                    end
                    total++;
                    if (if_rvalid_s[g] === 1'b1 || d_rvalid_s[g] === 1'b1) begin
                        if (sb.size() == 0) begin
                            bad++;
                            $display("FAIL rvalid_extra[%0d]: cycle %0d rvalid if/d=%b%b, required none", g, cyc,
                                     if_rvalid_s[g], d_rvalid_s[g]);
                        end else begin
                            e = sb.pop_front();
                            if ({if_rvalid_s[g], d_rvalid_s[g]} !== {~e.own, e.own} || e.due != cyc ||
                                (e.own ? d_rdata_s[g] : if_rdata_s[g]) !== e.data ||
                                (e.own ? if_rdata_s[g] : d_rdata_s[g]) !== 32'h0) begin
                                bad++;
                                $display("FAIL response[%0d]: cycle %0d rvalid if/d=%b%b rdata if/d=%h/%h, required owner %0d data %h at cycle %0d",
                                         g, cyc, if_rvalid_s[g], d_rvalid_s[g], if_rdata_s[g], d_rdata_s[g], e.own, e.data, e.due);
                            end
                        end
                    end else begin
                        if (if_rdata_s[g] !== 32'h0 || d_rdata_s[g] !== 32'h0) begin
                            bad++;
                            $display("FAIL rdata_idle[%0d]: cycle %0d rdata if/d=%h/%h, required 0/0", g, cyc,
                                     if_rdata_s[g], d_rdata_s[g]);
                        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                            bad++;
                            $display("FAIL rvalid_missing[%0d]: cycle %0d no rvalid, required one due at %0d", g, cyc, sb[0].due);
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int g, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (if_gnt_s[g] === 1'b1 || d_gnt_s[g] === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout[%0d]: got no grant in 20 cycles, required a grant", g);
        end
    endtask

    task automatic test_reset();
        if_req_s[0] = 1'b1; if_addr_s[0] = 32'h40;
        d_req_s[0] = 1'b1; d_wr_s[0] = 1'b0; d_addr_s[0] = 32'h200; d_wdata_s[0] = 32'h1111_1111;
        repeat (3) @(negedge clk);
        total++;
        if (d_gnt_s[0] !== 1'b0 || if_gnt_s[0] !== 1'b0 || mem_en_s[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: gnt if/d=%b%b mem_en=%b, required 0", if_gnt_s[0], d_gnt_s[0], mem_en_s[0]);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (d_gnt_s[0] !== 1'b1 || if_gnt_s[0] !== 1'b0 || mem_en_s[0] !== 1'b1 || mem_addr_s[0] !== 32'h200) begin
            bad++;
            $display("FAIL reset_release: gnt if/d=%b%b mem_en=%b addr=%h, required 01/1/00000200",
                     if_gnt_s[0], d_gnt_s[0], mem_en_s[0], mem_addr_s[0]);
        end
        tick();
        d_req_s[0] = 1'b0; if_req_s[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_fetch();
        logic ok;
        tick();
        if_addr_s[0] = 32'h40; if_req_s[0] = 1'b1;
        wait_gnt(0, ok);
        if (ok) begin
            tick();
            if_addr_s[0] = 32'h44;
            @(negedge clk);
            total++;
            if (if_gnt_s[0] !== 1'b0 || if_rvalid_s[0] !== 1'b1 || if_rdata_s[0] !== 32'h0050_0093) begin
                bad++;
                $display("FAIL fetch_resp: gnt=%b rvalid=%b rdata=%h, required 0/1/00500093",
                         if_gnt_s[0], if_rvalid_s[0], if_rdata_s[0]);
            end
            @(negedge clk);
            total++;
            if (if_gnt_s[0] !== 1'b1 || mem_addr_s[0] !== 32'h44) begin
                bad++;
                $display("FAIL fetch_next: gnt=%b addr=%h at T+2, required 1/00000044", if_gnt_s[0], mem_addr_s[0]);
            end
        end
        tick();
        if_req_s[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_store();
        logic ok;
        tick();
        d_wr_s[1] = 1'b1; d_addr_s[1] = 32'h100; d_wdata_s[1] = 32'hDEAD_BEEF; d_req_s[1] = 1'b1;
        wait_gnt(1, ok);
        if (ok) begin
            total++;
            if (d_gnt_s[1] !== 1'b1 || mem_wr_s[1] !== 1'b1 || mem_addr_s[1] !== 32'h100 || mem_wdata_s[1] !== 32'hDEAD_BEEF) begin
                bad++;
                $display("FAIL store_cmd: gnt=%b wr=%b addr=%h wdata=%h, required 1/1/00000100/deadbeef",
                         d_gnt_s[1], mem_wr_s[1], mem_addr_s[1], mem_wdata_s[1]);
            end
            tick();
            d_req_s[1] = 1'b0; d_wr_s[1] = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (k > 1) @(negedge clk);
                else @(negedge clk);
                total++;
                if (d_rvalid_s[1] !== (k == 3) || d_rdata_s[1] !== 32'h0) begin
                    bad++;
                    $display("FAIL store_resp: T+%0d rvalid=%b rdata=%h, required %b/00000000",
                             k, d_rvalid_s[1], d_rdata_s[1], (k == 3));
                end
            end
        end else begin
            d_req_s[1] = 1'b0; d_wr_s[1] = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_starvation();
        logic       ok;
        logic [9:0] pat;
        pat = 10'b10_0001_0000;
        tick();
        if_addr_s[0] = 32'h48; d_addr_s[0] = 32'h204; d_wr_s[0] = 1'b0; d_wdata_s[0] = 32'h2222_2222;
        if_req_s[0] = 1'b1; d_req_s[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_gnt(0, ok);
            total++;
            if (if_gnt_s[0] !== pat[k] || d_gnt_s[0] !== !pat[k]) begin
                bad++;
                $display("FAIL starve_seq: grant %0d if/d=%b%b, required %b%b", k, if_gnt_s[0], d_gnt_s[0], pat[k], !pat[k]);
            end
        end
        tick();
        if_req_s[0] = 1'b0; d_req_s[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic ok;
        tick();
        if_addr_s[1] = 32'h80; d_addr_s[1] = 32'h300; d_wr_s[1] = 1'b0; d_wdata_s[1] = 32'h0;
        if_req_s[1] = 1'b1; d_req_s[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1, ok);
            total++;
            if (d_gnt_s[1] !== 1'b1) begin
                bad++;
                $display("FAIL midrst_pre: grant %0d d_gnt=%b, required 1", k, d_gnt_s[1]);
            end
        end
        tick();
        if_req_s[1] = 1'b0; d_req_s[1] = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (d_rvalid_s[1] !== 1'b0 || mem_en_s[1] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_hold: rvalid=%b mem_en=%b, required 0/0", d_rvalid_s[1], mem_en_s[1]);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (d_rvalid_s[1] !== 1'b0 || if_rvalid_s[1] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_norv: rvalid if/d=%b%b at T+3, required 00", if_rvalid_s[1], d_rvalid_s[1]);
        end
        tick();
        if_req_s[1] = 1'b1; d_req_s[1] = 1'b1;
        @(negedge clk);
        total++;
        if (d_gnt_s[1] !== 1'b1 || if_gnt_s[1] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_starve: gnt if/d=%b%b after release, required 01", if_gnt_s[1], d_gnt_s[1]);
        end
        tick();
        if_req_s[1] = 1'b0; d_req_s[1] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_withdraw();
        logic ok;
        tick();
        if_addr_s[1] = 32'h40; if_req_s[1] = 1'b1;
        wait_gnt(1, ok);
        tick();
        if_req_s[1] = 1'b0; d_req_s[1] = 1'b1; d_addr_s[1] = 32'h304; d_wr_s[1] = 1'b0;
        @(negedge clk);
        total++;
        if (d_gnt_s[1] !== 1'b0 || mem_en_s[1] !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_wait: d_gnt=%b mem_en=%b, required 0/0", d_gnt_s[1], mem_en_s[1]);
        end
        tick();
        d_req_s[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (d_gnt_s[1] !== 1'b0 || mem_en_s[1] !== 1'b0) begin
                bad++;
                $display("FAIL withdraw_after: step %0d d_gnt=%b mem_en=%b, required 0/0", k, d_gnt_s[1], mem_en_s[1]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_req_s[i] = 1'b0; if_addr_s[i] = 32'h0;
            d_req_s[i] = 1'b0; d_wr_s[i] = 1'b0; d_addr_s[i] = 32'h0; d_wdata_s[i] = 32'h0;
        end
        test_reset();
        test_fetch();
        test_store();
        test_starvation();
        test_reset_mid();
        test_withdraw();
        repeat (4) @(negedge clk);
        total++;
        if (gen_inst[0].sb.size() != 0) begin
            bad++;
            $display("FAIL drain0: %0d responses outstanding, required 0", gen_inst[0].sb.size());
        end
        total++;
        if (gen_inst[1].sb.size() != 0) begin
            bad++;
            $display("FAIL drain1: %0d responses outstanding, required 0", gen_inst[1].sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
